// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the 4-slave decode/default-slave subsystem.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam int unsigned REGION_W    = 4;
  localparam int unsigned NUM_SLAVES  = 4;
  localparam int unsigned SLV_IDX_W   = 2;
  localparam int unsigned REGION_SLV0 = 0;
  localparam int unsigned REGION_LAST = 3;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // One-hot select for a mapped slave index.
  function automatic logic [NUM_SLAVES-1:0] onehot_sel(input logic [SLV_IDX_W-1:0] idx);
    return NUM_SLAVES'(1) << idx;
  endfunction

endpackage

// File: rtl/ahb_decode_ctrl_if.sv
// Bus-side signal bundle between the AHB master/mux fabric and the decode controller.
interface ahb_decode_ctrl_if
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ERRCNT_W = 8
);

  logic [ADDR_W-1:0]     haddr;
  logic [1:0]            htrans;
  logic                  mux_hreadyout;
  logic                  mux_hresp;
  logic [NUM_SLAVES-1:0] hsel;
  logic [SLV_IDX_W-1:0]  mux_sel;
  logic                  hready;
  logic                  hresp;
  logic [ERRCNT_W-1:0]   err_count;

  modport master (
    output haddr, htrans, mux_hreadyout, mux_hresp,
    input  hsel, mux_sel, hready, hresp, err_count
  );

  modport slave (
    input  haddr, htrans, mux_hreadyout, mux_hresp,
    output hsel, mux_sel, hready, hresp, err_count
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Internal default slave: two-cycle ERROR sequencer plus saturating error counter.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                start,
  output logic                busy_err1,
  output logic                err2,
  output logic [ERRCNT_W-1:0] err_count
);

  ds_state_e           r_state;
  ds_state_e           w_state_next;
  logic                w_enter_err1;
  logic [ERRCNT_W-1:0] r_err_count;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= DS_IDLE;
    else        r_state <= w_state_next;
  end

  // ERR2 overlaps the next address phase, so a new unmapped access re-enters ERR1 directly.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DS_IDLE: if (start) w_state_next = DS_ERR1;
      DS_ERR1: w_state_next = DS_ERR2;
      DS_ERR2: w_state_next = start ? DS_ERR1 : DS_IDLE;
      default: w_state_next = DS_IDLE;
    endcase
  end

  assign w_enter_err1 = (w_state_next == DS_ERR1) && (r_state != DS_ERR1);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_err_count <= '0;
    end else if (w_enter_err1 && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

  assign busy_err1 = (r_state == DS_ERR1);
  assign err2      = (r_state == DS_ERR2);
  assign err_count = r_err_count;

endmodule

// File: rtl/ahb_decode_ctrl.sv
// AHB-Lite address decoder, data-phase sequencer and HREADY/HRESP merge for 4 slaves.
module ahb_decode_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REGION_W = ahb_pkg::REGION_W,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic              hclk,
  input  logic              hreset,
  ahb_decode_ctrl_if.slave  bus
);

  logic [REGION_W-1:0]  w_region;
  logic                 w_mapped;
  logic                 w_active;
  logic                 w_accept;
  logic                 w_start;
  logic [SLV_IDX_W-1:0] r_mux_sel;
  logic                 r_dp_map;
  logic                 r_dp_def;
  logic                 w_busy_err1;
  logic                 w_err2;
  logic [ERRCNT_W-1:0]  w_err_count;

  assign w_region = bus.haddr[ADDR_W-1 -: REGION_W];
  assign w_mapped = (w_region >= REGION_W'(REGION_SLV0)) && (w_region <= REGION_W'(REGION_LAST));
  assign w_active = bus.htrans[1];
  assign w_accept = bus.hready;
  assign w_start  = w_accept & w_active & ~w_mapped;

  always_comb begin
    bus.hsel = '0;
    if (w_mapped) bus.hsel = onehot_sel(w_region[SLV_IDX_W-1:0]);
  end

  // Data-phase context; everything holds while the current data phase is stalled.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_mux_sel <= '0;
      r_dp_map  <= 1'b0;
      r_dp_def  <= 1'b0;
    end else if (w_accept) begin
      if (w_mapped) r_mux_sel <= w_region[SLV_IDX_W-1:0];
      r_dp_map <= w_active & w_mapped;
      r_dp_def <= w_start;
    end
  end

  ahb_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_default_slave (
    .hclk      (hclk),
    .hreset    (hreset),
    .start     (w_start),
    .busy_err1 (w_busy_err1),
    .err2      (w_err2),
    .err_count (w_err_count)
  );

  // Default-slave ERROR phases win over the mux; idle/BUSY data phases get a local zero-wait OKAY.
  always_comb begin
    bus.hready = 1'b1;
    bus.hresp  = HRESP_OKAY;
    if (w_busy_err1) begin
      bus.hready = 1'b0;
      bus.hresp  = HRESP_ERROR;
    end else if (w_err2) begin
      bus.hready = 1'b1;
      bus.hresp  = HRESP_ERROR;
    end else if (r_dp_map && !r_dp_def) begin
      bus.hready = bus.mux_hreadyout;
      bus.hresp  = bus.mux_hresp;
    end
  end

  assign bus.mux_sel   = r_mux_sel;
  assign bus.err_count = w_err_count;

endmodule

// File: tb/tb_ahb_decode_ctrl.sv
// Scoreboard bench for ahb_decode_ctrl: driver queues per-cycle expectations, monitor checks at negedge.
module tb_ahb_decode_ctrl;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned ERRCNT_W = 8;

  logic hclk = 1'b0;
  logic hreset;

  always #5 hclk = ~hclk;

  ahb_decode_ctrl_if #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) bus ();

  ahb_decode_ctrl #(
    .ADDR_W   (ADDR_W),
    .REGION_W (4),
    .ERRCNT_W (ERRCNT_W)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.slave)
  );

  typedef struct {
    string      name;
    logic [3:0] hsel;
    logic       hready;
    logic       hresp;
    logic [1:0] mux_sel;
    logic [7:0] err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic rdy, input logic rsp);
    bus.haddr         = a;
    bus.htrans        = t;
    bus.mux_hreadyout = rdy;
    bus.mux_hresp     = rsp;
  endtask

  // One bus cycle: drive after the edge and queue the response expected before the next edge.
  task automatic cyc(input logic [31:0] a, input logic [1:0] t, input logic rdy, input logic rsp,
                     input logic [3:0] e_hsel, input logic e_rdy, input logic e_rsp,
                     input logic [1:0] e_ms, input logic [7:0] e_err, input string nm);
    exp_t e;
    @(posedge hclk);
    #1;
    drive(a, t, rdy, rsp);
    e.name = nm; e.hsel = e_hsel; e.hready = e_rdy; e.hresp = e_rsp; e.mux_sel = e_ms; e.err = e_err;
    q.push_back(e);
  endtask

  task automatic cyc_nochk(input logic [31:0] a, input logic [1:0] t);
    @(posedge hclk);
    #1;
    drive(a, t, 1'b1, 1'b0);
  endtask

  task automatic check_now(input string nm, input logic [3:0] e_hsel, input logic e_rdy,
                           input logic e_rsp, input logic [1:0] e_ms, input logic [7:0] e_err);
    checks++;
    if ({bus.hsel, bus.hready, bus.hresp, bus.mux_sel, bus.err_count} !== {e_hsel, e_rdy, e_rsp, e_ms, e_err}) begin
      errors++;
      $display("FAIL %s: got hsel=%b hready=%b hresp=%b mux_sel=%b err=%0d, want hsel=%b hready=%b hresp=%b mux_sel=%b err=%0d",
               nm, bus.hsel, bus.hready, bus.hresp, bus.mux_sel, bus.err_count,
               e_hsel, e_rdy, e_rsp, e_ms, e_err);
    end
  endtask

  // Monitor: pops one expectation per cycle in which the driver queued one.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_now(e.name, e.hsel, e.hready, e.hresp, e.mux_sel, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1;
    drive(32'h0, 2'b00, 1'b1, 1'b0);
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    #1 check_now("reset_state", 4'b0001, 1'b1, 1'b0, 2'b00, 8'd0);

    // mapped read to slave 2
    cyc(32'h2000_0010, 2'b10, 1, 0, 4'b0100, 1, 0, 2'b00, 8'd0, "map_addr");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 0, 2'b10, 8'd0, "map_data");
    // slave 1 with three wait states; NONSEQ to 0x0 during waits must be ignored
    cyc(32'h1000_0000, 2'b10, 1, 0, 4'b0010, 1, 0, 2'b00, 8'd0, "ws_addr");
    cyc(32'h0000_0000, 2'b10, 0, 0, 4'b0001, 0, 0, 2'b01, 8'd0, "ws_wait1");
    cyc(32'h0000_0000, 2'b10, 0, 0, 4'b0001, 0, 0, 2'b01, 8'd0, "ws_wait2");
    cyc(32'h0000_0000, 2'b10, 0, 0, 4'b0001, 0, 0, 2'b01, 8'd0, "ws_wait3");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 0, 2'b01, 8'd0, "ws_done");
    cyc(32'h3000_0000, 2'b00, 0, 0, 4'b1000, 1, 0, 2'b00, 8'd0, "idle_okay");
    // single unmapped access
    cyc(32'h8000_0000, 2'b10, 1, 0, 4'b0000, 1, 0, 2'b11, 8'd0, "unmap_addr");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 0, 1, 2'b11, 8'd1, "unmap_err1");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 1, 2'b11, 8'd1, "unmap_err2");
    // slave ERROR passes through the mux path
    cyc(32'h1000_0000, 2'b10, 1, 0, 4'b0010, 1, 0, 2'b00, 8'd1, "slverr_addr");
    cyc(32'h0000_0000, 2'b00, 0, 1, 4'b0001, 0, 1, 2'b01, 8'd1, "slverr_c1");
    cyc(32'h0000_0000, 2'b00, 1, 1, 4'b0001, 1, 1, 2'b01, 8'd1, "slverr_c2");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 0, 2'b00, 8'd1, "slverr_done");
    // back-to-back unmapped NONSEQ/SEQ, then mapped access out of ERR2
    cyc(32'hF000_0000, 2'b10, 1, 0, 4'b0000, 1, 0, 2'b00, 8'd1, "b2b_addr0");
    cyc(32'hF000_0004, 2'b11, 1, 0, 4'b0000, 0, 1, 2'b00, 8'd2, "b2b_err1a");
    cyc(32'hF000_0004, 2'b11, 1, 0, 4'b0000, 1, 1, 2'b00, 8'd2, "b2b_err2a");
    cyc(32'h3000_0004, 2'b10, 1, 0, 4'b1000, 0, 1, 2'b00, 8'd3, "b2b_err1b");
    cyc(32'h3000_0004, 2'b10, 1, 0, 4'b1000, 1, 1, 2'b00, 8'd3, "b2b_err2b");
    cyc(32'h0000_0000, 2'b00, 0, 0, 4'b0001, 0, 0, 2'b11, 8'd3, "after_err2");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 0, 2'b11, 8'd3, "after_err2_done");
    // BUSY to slave 3 is not active: zero-wait OKAY even with slave stalling
    cyc(32'h3000_0000, 2'b01, 1, 0, 4'b1000, 1, 0, 2'b00, 8'd3, "busy_addr");
    cyc(32'h3000_0000, 2'b00, 0, 0, 4'b1000, 1, 0, 2'b11, 8'd3, "busy_data");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 0, 2'b11, 8'd3, "busy_after");

    // 300 back-to-back unmapped accesses drive the counter into saturation
    for (int i = 0; i < 600; i++) cyc_nochk(32'hF000_0000, 2'b10);
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 1, 2'b00, 8'd255, "sat_err2");
    cyc(32'h2000_0000, 2'b10, 1, 0, 4'b0100, 1, 0, 2'b00, 8'd255, "sat_idle");
    cyc(32'h9000_0000, 2'b10, 1, 0, 4'b0000, 1, 0, 2'b10, 8'd255, "pre_rst_addr");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 0, 1, 2'b10, 8'd255, "pre_rst_err1");

    // asynchronous reset in the middle of ERR1
    @(negedge hclk);
    #1 hreset = 1'b1;
    #1 check_now("async_reset", 4'b0001, 1'b1, 1'b0, 2'b00, 8'd0);
    @(posedge hclk);
    #1 hreset = 1'b0;
    cyc(32'h1000_0000, 2'b10, 1, 0, 4'b0010, 1, 0, 2'b00, 8'd0, "post_rst_addr");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 0, 2'b01, 8'd0, "post_rst_data");
    cyc(32'h0000_0000, 2'b00, 1, 0, 4'b0001, 1, 0, 2'b00, 8'd0, "post_rst_idle");

    @(negedge hclk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_decode_ctrl.md
Name: ahb_decode_ctrl

Overview:
- Address-phase decoder and data-phase sequencer for the 4-slave AHB-Lite subsystem.
- Decodes HADDR into one-hot slave selects and registers the slave index into the data phase. That index drives the read-response multiplexer select.
- Contains an internal default slave that answers unmapped accesses with the two-cycle AHB ERROR response.
- Merges the mux response and the default-slave response into the master-facing HREADY/HRESP.

Parameters:
- ADDR_W, 32, HADDR width.
- REGION_W, 4, number of HADDR MSBs used for region decode.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- hclk  input  1  bus clock; all state on rising edge.
- hreset  input  1  asynchronous, active-high reset.
- haddr  input  ADDR_W  master address-phase address.
- htrans  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- mux_hreadyout  input  1  HREADYOUT of the slave currently selected by the mux.
- mux_hresp  input  1  HRESP of the slave currently selected by the mux.
- hsel  output  4  one-hot slave select, combinational from haddr.
- mux_sel  output  2  registered data-phase slave index to the read mux.
- hready  output  1  global HREADY to the master and all slaves.
- hresp  output  1  global HRESP to the master (0 OKAY, 1 ERROR).
- err_count  output  ERRCNT_W  saturating count of default-slave ERROR responses.

Behaviour:
- Clock and reset: one clock, hclk. Reset hreset is asynchronous and active-high.
- Region decode: region = haddr[ADDR_W-1 -: REGION_W].
  - Region 0,1,2,3 maps to slave index 0,1,2,3, with hsel bit = 1<<index.
  - Any other region is unmapped: hsel = 0000.
  - hsel is combinational and independent of htrans.
- Address-phase acceptance: a phase is accepted on a rising edge where hready=1. It is "active" when htrans[1]=1 (NONSEQ or SEQ).
- On every accepted phase, the following register updates happen:
  - mux_sel <= region index if mapped; otherwise it holds its previous value.
  - dp_map <= active & mapped.
  - dp_def <= active & unmapped.
  - When hready=0, all of these hold.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 when dp_def is loaded as 1.
  - ERR1 -> ERR2 unconditionally on the next edge.
  - ERR2 -> ERR1 if a new unmapped active phase is accepted in that cycle; otherwise ERR2 -> IDLE.
- Output merge, by priority:
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
  - dp_map=1: hready=mux_hreadyout, hresp=mux_hresp. Slave multi-cycle ERROR passes through unchanged.
  - Otherwise (no transfer, or an IDLE/BUSY data phase): hready=1, hresp=0. This is a zero-wait OKAY generated locally.
- Latency:
  - Decode to hsel is 0 cycles.
  - mux_sel is valid 1 cycle after acceptance.
  - An unmapped access completes in exactly 2 data-phase cycles.
- err_count: increments by 1 on each entry into ERR1 and saturates at all-ones. It never wraps.
- Boundary conditions:
  - Back-to-back unmapped accesses: ERR2 overlaps the next address phase, so each access takes 2 cycles.
  - Mapped access after ERR2: mux_sel updates on the ERR2 edge and the FSM returns to IDLE.
  - Wait states: with mux_hreadyout=0, mux_sel, dp_* and FSM state all hold.
  - BUSY during a burst: not counted as active, so the response is an OKAY zero-wait.
  - htrans or haddr changes while hready=0 are ignored.
- Reset values, applied asynchronously, including mid-transfer:
  - mux_sel=00, dp_map=0, dp_def=0, FSM=IDLE, err_count=0.
  - Hence hready=1 and hresp=0 as soon as hreset asserts.
  - The first edge after hreset deasserts samples a fresh address phase.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
  - HRESP codes: OKAY, ERROR.
  - REGION_W and the slave region constants.
  - Default-slave state encodings: IDLE=2'd0, ERR1=2'd1, ERR2=2'd2.
- Sub-module ahb_default_slave holds the IDLE/ERR1/ERR2 FSM and err_count.
  - Inputs: hclk, hreset, start (unmapped active phase accepted).
  - Outputs: busy_err1, err2, err_count.

Test Plan:
- Reset: assert hreset mid-ERR1 -> hready=1, hresp=0, mux_sel=00, err_count=0 immediately, without waiting for a clock edge.
- Mapped read: haddr=0x2000_0010, htrans=10, mux_hreadyout=1 -> hsel=0100 in the same cycle; mux_sel=10 next cycle; hready=1, hresp=0.
- Wait states: slave 1 access with mux_hreadyout low for 3 cycles -> hready low for 3 cycles; mux_sel=01 held; a new haddr=0x0000_0000 presented during the waits is not sampled.
- Unmapped: haddr=0x8000_0000, htrans=10 -> hsel=0000; next cycle hready=0, hresp=1; following cycle hready=1, hresp=1; then OKAY; err_count=1.
- Back-to-back unmapped, NONSEQ then SEQ at 0xF000_0000/0xF000_0004 -> ERR1, ERR2, ERR1, ERR2 with no IDLE gap; err_count=2.
- Saturation and BUSY: 300 unmapped accesses -> err_count=255. Separately, htrans=01 to slave 3 -> hready=1, hresp=0, mux_sel=11.
